// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester-side and transmitter-side signals of uart_tx_arbiter.
// Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 7
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      tx_load;
    logic [DATA_W-1:0]         tx_data;
    logic                      busy;
    logic [2:0]                grant_id;

    modport master (
        output req, req_data,
        input  ack, tx_load, tx_data, busy, grant_id
    );

    modport slave (
        input  req, req_data,
        output ack, tx_load, tx_data, busy, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Shares one UART transmitter among NUM_REQ requesters, timing each
//            frame with its own counter. Define UART_TX_ARB_FIXED_PRIO_EN for
//            fixed priority instead of round-robin.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 7,
    parameter int FRAME_CYCLES = 90
) (
    input  wire logic        sys_clk,
    input  wire logic        reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int                 c_CNT_W    = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES - 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(FRAME_CYCLES - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [NUM_REQ-1:0]   r_ack,   w_ack_nxt;
    logic                 r_load,  w_load_nxt;
    logic [DATA_W-1:0]    r_data,  w_data_nxt;
    logic                 r_busy,  w_busy_nxt;
    logic [2:0]           r_gid,   w_gid_nxt;

    logic                 w_found;
    logic [2:0]           w_win;
    logic [DATA_W-1:0]    w_win_data;
    logic [NUM_REQ-1:0]   w_win_onehot;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the one left standing.
    always_comb begin
        w_found      = 1'b0;
        w_win        = '0;
        w_win_data   = '0;
        w_win_onehot = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_found         = 1'b1;
                w_win           = 3'(i);
                w_win_data      = bus.req_data[i*DATA_W +: DATA_W];
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
            end
        end
    end
`else
    logic [2:0] r_last, w_last_nxt;
    logic [3:0] w_best;

    // Winner is the requester at the smallest rotational distance past r_last.
    always_comb begin
        w_found      = 1'b0;
        w_win        = '0;
        w_win_data   = '0;
        w_win_onehot = '0;
        w_best       = 4'(NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i] &&
                (4'((i + 2*NUM_REQ - 1 - int'(r_last)) % NUM_REQ) < w_best)) begin
                w_best          = 4'((i + 2*NUM_REQ - 1 - int'(r_last)) % NUM_REQ);
                w_found         = 1'b1;
                w_win           = 3'(i);
                w_win_data      = bus.req_data[i*DATA_W +: DATA_W];
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ack_nxt   = '0;
        w_load_nxt  = 1'b0;
        w_data_nxt  = r_data;
        w_busy_nxt  = r_busy;
        w_gid_nxt   = r_gid;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
        w_last_nxt  = r_last;
`endif
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (w_found) begin
                    w_state_nxt = S_LOAD;
                    w_load_nxt  = 1'b1;
                    w_data_nxt  = w_win_data;
                    w_ack_nxt   = w_win_onehot;
                    w_gid_nxt   = w_win;
                    w_busy_nxt  = 1'b1;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
                    w_last_nxt  = w_win;
`endif
                end
            end
            S_LOAD: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = c_CNT_LOAD;
                w_busy_nxt  = 1'b1;
            end
            S_WAIT: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= '0;
            r_load  <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_gid   <= '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            r_last  <= 3'(NUM_REQ - 1);
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            r_load  <= w_load_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= w_busy_nxt;
            r_gid   <= w_gid_nxt;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            r_last  <= w_last_nxt;
`endif
        end
    end

    assign bus.ack      = r_ack;
    assign bus.tx_load  = r_load;
    assign bus.tx_data  = r_data;
    assign bus.busy     = r_busy;
    assign bus.grant_id = r_gid;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Scoreboard bench for uart_tx_arbiter (NUM_REQ=4, FRAME_CYCLES=20).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 7;
    localparam int FC = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) rif ();

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .FRAME_CYCLES(FC)) dut (
        .sys_clk (clk),
        .reset   (rst_n),
        .bus     (rif.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int            cyc;
        int            id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: an arbitration decision is possible whenever the block
    // has been free since free_at; a decision yields a load one cycle later.
    logic [NR-1:0] req_v;
    logic [DW-1:0] data_v [NR];
    logic          rst_drv;
    int free_at    = 0;
    int last_gnt   = NR - 1;
    int busy_from  = 0;
    int busy_until = -1;
    int gnt_w;
    bit gnt_hit;

    function automatic int pick(logic [NR-1:0] r);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NR; i++)
            if (r[i]) return i;
`else
        for (int d = 1; d <= NR; d++)
            if (r[(last_gnt + d) % NR]) return (last_gnt + d) % NR;
`endif
        return 0;
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        rst_n    = rst_drv;
        rif.req  = req_v;
        for (int i = 0; i < NR; i++) rif.req_data[i*DW +: DW] = data_v[i];
        gnt_hit = 0;
        if (!rst_drv) begin
            free_at  = 0;
            last_gnt = NR - 1;
            if (busy_until > cyc) busy_until = cyc;
        end else if (cyc >= free_at && req_v != '0) begin
            gnt_w  = pick(req_v);
            e.cyc  = cyc + 1;
            e.id   = gnt_w;
            e.data = data_v[gnt_w];
            exp_q.push_back(e);
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            last_gnt = gnt_w;
`endif
            free_at    = cyc + 1 + FC;
            busy_from  = cyc + 1;
            busy_until = cyc + FC;
            gnt_hit    = 1;
        end
    endtask

    task automatic run_grants(int n, bit drop);
        int got = 0;
        int budget = n * (FC + 2) + 10;
        while (got < n && budget > 0) begin
            tick();
            budget--;
            if (gnt_hit) begin
                got++;
                if (drop) req_v[gnt_w] = 1'b0;
            end
        end
    endtask

    task automatic check_reset(string name);
        vectors++;
        if ({rif.tx_load, rif.ack, rif.busy, rif.tx_data, rif.grant_id} !== '0) begin
            miscompares++;
            $display("FAIL %s: load=%b ack=%b busy=%b data=%h gid=%0d, required all zero",
                     name, rif.tx_load, rif.ack, rif.busy, rif.tx_data, rif.grant_id);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t          e;
        logic          eb;
        logic [NR-1:0] ea;
        eb = (cyc >= busy_from) && (cyc <= busy_until);
        vectors++;
        if (rif.busy !== eb) begin
            miscompares++;
            $display("FAIL busy @%0d: got %b, required %b", cyc, rif.busy, eb);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_load: no tx_load at cycle %0d, required id=%0d data=%h",
                     e.cyc, e.id, e.data);
        end
        if (rif.tx_load === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_load @%0d: got id=%0d data=%h, required no load",
                         cyc, rif.grant_id, rif.tx_data);
            end else begin
                e  = exp_q.pop_front();
                ea = '0;
                ea[e.id] = 1'b1;
                if (e.cyc != cyc || int'(rif.grant_id) != e.id ||
                    rif.tx_data !== e.data || rif.ack !== ea) begin
                    miscompares++;
                    $display("FAIL load: got cyc=%0d id=%0d data=%h ack=%b, required cyc=%0d id=%0d data=%h ack=%b",
                             cyc, rif.grant_id, rif.tx_data, rif.ack, e.cyc, e.id, e.data, ea);
                end
            end
        end else if (rif.ack !== '0) begin
            vectors++;
            miscompares++;
            $display("FAIL stray_ack @%0d: got ack=%b, required 0", cyc, rif.ack);
        end
    end

    initial begin
        rst_drv      = 1'b0;
        rst_n        = 1'b0;
        req_v        = '0;
        rif.req      = '0;
        rif.req_data = '0;
        for (int i = 0; i < NR; i++) data_v[i] = '0;

        repeat (3) tick();
        check_reset("reset_state");
        rst_drv = 1'b1;
        tick();

        // Single requester held for two characters.
        req_v[2]  = 1'b1;
        data_v[2] = 7'h55;
        run_grants(2, 1'b0);
        req_v = '0;
        repeat (FC + 3) tick();

        // Fresh pointer, then all four requesters, each dropping after its ack.
        rst_drv = 1'b0;
        repeat (2) tick();
        rst_drv = 1'b1;
        data_v[0] = 7'h11; data_v[1] = 7'h22; data_v[2] = 7'h33; data_v[3] = 7'h44;
        req_v = 4'b1111;
        run_grants(4, 1'b1);
        req_v = '0;
        repeat (FC + 3) tick();

        // Rotation with requesters 0 and 3 both held.
        data_v[0] = 7'h0a; data_v[3] = 7'h3c;
        req_v = 4'b1001;
        run_grants(2, 1'b0);
        req_v = '0;
        repeat (FC + 3) tick();

        // Request raised and withdrawn inside a frame.
        req_v[0]  = 1'b1;
        data_v[0] = 7'h61;
        run_grants(1, 1'b1);
        repeat (3) tick();
        req_v[1]  = 1'b1;
        data_v[1] = 7'h7e;
        repeat (5) tick();
        req_v[1] = 1'b0;
        repeat (FC + 3) tick();

        // Reset in the seventh cycle of a frame, requesters 1 and 3 pending.
        req_v[2]  = 1'b1;
        data_v[2] = 7'h2d;
        run_grants(1, 1'b1);
        repeat (6) tick();
        req_v     = 4'b1010;
        data_v[1] = 7'h19;
        data_v[3] = 7'h39;
        rst_drv   = 1'b0;
        tick();
        tick();
        check_reset("reset_mid_frame");
        rst_drv = 1'b1;
        run_grants(1, 1'b1);
        req_v = '0;
        repeat (FC + 3) tick();

        // Randomised traffic including withdrawals and repeat requests.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_v[i] && ($urandom % 6) == 0) begin
                    req_v[i]  = 1'b1;
                    data_v[i] = DW'($urandom);
                end else if (req_v[i] && ($urandom % 50) == 0) begin
                    req_v[i] = 1'b0;
                end
            end
            tick();
            if (gnt_hit) begin
                if ($urandom % 2) req_v[gnt_w] = 1'b0;
                else              data_v[gnt_w] = DW'($urandom);
            end
        end

        req_v = '0;
        repeat (FC + 5) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d loads outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
